// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file writeback path.
package rf_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;

    // One buffered accelerator result awaiting the write port.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; no bypass, so a push is visible at head next cycle.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    wb_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW:0]       count_q;
    logic              push_en;
    logic              pop_en;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    // A full FIFO refuses a push even if it pops in the same cycle.
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push_en && !pop_en)      count_q <= count_q + (PW+1)'(1);
            else if (!push_en && pop_en) count_q <= count_q - (PW+1)'(1);
        end
    end

    // Entry storage; contents are don't-care while the slot is not occupied.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: core writeback has priority, accelerator results are
// buffered and drained in idle cycles; a busy scoreboard drives decode stalls.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_we,
    input  logic [REG_AW-1:0] core_rd,
    input  logic [XLEN-1:0]   core_wdata,
    input  logic              acc_valid,
    output logic              acc_ready,
    input  logic [REG_AW-1:0] acc_rd,
    input  logic [XLEN-1:0]   acc_wdata,
    input  logic              issue_acc,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] chk_rs1,
    input  logic [REG_AW-1:0] chk_rs2,
    input  logic [REG_AW-1:0] chk_rd,
    output logic              stall,
    output logic              write_reg,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   data_in,
    output logic [NUM_REGS-1:0] busy
);

    wb_entry_t           fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop_commit;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // The FIFO only drains in cycles the core leaves the port free.
    assign pop_commit = ~core_we & ~fifo_empty;
    assign acc_ready  = ~fifo_full;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (acc_valid),
        .pop   (pop_commit),
        .din   ('{rd: acc_rd, data: acc_wdata}),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Write-port mux: core first, then FIFO head, else idle; x0 is never written.
    always_comb begin
        write_reg = 1'b0;
        rd        = '0;
        data_in   = '0;
        if (core_we) begin
            write_reg = (core_rd != '0);
            rd        = core_rd;
            data_in   = core_wdata;
        end else if (!fifo_empty) begin
            write_reg = (fifo_head.rd != '0);
            rd        = fifo_head.rd;
            data_in   = fifo_head.data;
        end
    end

    // Scoreboard next state: clear on commit, then set on issue so a new op supersedes.
    always_comb begin
        busy_d = busy_q;
        if (pop_commit) busy_d[fifo_head.rd] = 1'b0;
        if (issue_acc)  busy_d[issue_rd]     = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign stall = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd];
    assign busy  = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected writes go into a queue and a negedge
// monitor compares every register-file write against it; state checks are inline.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic        clk;
    logic        reset;
    logic        core_we;
    logic [4:0]  core_rd;
    logic [31:0] core_wdata;
    logic        acc_valid;
    logic        acc_ready;
    logic [4:0]  acc_rd;
    logic [31:0] acc_wdata;
    logic        issue_acc;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic [4:0]  chk_rd;
    logic        stall;
    logic        write_reg;
    logic [4:0]  rd;
    logic [31:0] data_in;
    logic [31:0] busy;

    int checks   = 0;
    int failures = 0;
    wb_entry_t exp_q[$];
    wb_entry_t mon_e;

    rf_wb_arbiter #(
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .core_we    (core_we),
        .core_rd    (core_rd),
        .core_wdata (core_wdata),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc_rd     (acc_rd),
        .acc_wdata  (acc_wdata),
        .issue_acc  (issue_acc),
        .issue_rd   (issue_rd),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .chk_rd     (chk_rd),
        .stall      (stall),
        .write_reg  (write_reg),
        .rd         (rd),
        .data_in    (data_in),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wb(input logic [4:0] r, input logic [31:0] d);
        wb_entry_t e;
        e.rd   = r;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Every committed write must match the oldest expected write, in order.
    always @(negedge clk) begin
        if (!reset && write_reg) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%08h, expected no write",
                         rd, data_in);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_rd", {27'b0, rd}, {27'b0, mon_e.rd});
                check("wb_data", data_in, mon_e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; core_we = 1'b0; core_rd = '0; core_wdata = '0;
        acc_valid = 1'b0; acc_rd = '0; acc_wdata = '0;
        issue_acc = 1'b0; issue_rd = '0; chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_acc_ready", {31'b0, acc_ready}, 32'd1);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_write_reg", {31'b0, write_reg}, 32'd0);
        check("rst_rd", {27'b0, rd}, 32'd0);
        check("rst_data_in", data_in, 32'd0);
        check("rst_busy", busy, 32'd0);

        // Core pass-through, zero latency
        step();
        core_we = 1'b1; core_rd = 5'd5; core_wdata = 32'h11;
        expect_wb(5'd5, 32'h11);
        @(negedge clk);
        check("core_write_reg", {31'b0, write_reg}, 32'd1);
        check("core_acc_ready", {31'b0, acc_ready}, 32'd1);
        check("core_stall", {31'b0, stall}, 32'd0);
        step();
        core_rd = 5'd0; core_wdata = 32'h55;
        @(negedge clk);
        check("core_x0_no_write", {31'b0, write_reg}, 32'd0);
        step();
        core_we = 1'b0;

        // Scoreboard set, accelerator return, clear one cycle after the write
        issue_acc = 1'b1; issue_rd = 5'd7; chk_rs1 = 5'd7;
        @(negedge clk);
        check("stall_same_cycle", {31'b0, stall}, 32'd0);
        step();
        issue_acc = 1'b0;
        acc_valid = 1'b1; acc_rd = 5'd7; acc_wdata = 32'hABCD;
        @(negedge clk);
        check("stall_after_issue", {31'b0, stall}, 32'd1);
        check("busy_after_issue", busy, 32'h0000_0080);
        check("no_bypass", {31'b0, write_reg}, 32'd0);
        step();
        acc_valid = 1'b0;
        expect_wb(5'd7, 32'hABCD);
        @(negedge clk);
        check("acc_write_lat1", {31'b0, write_reg}, 32'd1);
        check("stall_during_pop", {31'b0, stall}, 32'd1);
        step();
        @(negedge clk);
        check("stall_cleared", {31'b0, stall}, 32'd0);
        check("busy_cleared", busy, 32'd0);
        chk_rs1 = 5'd0;

        // Accelerator result deferred behind three core writes
        step();
        core_we = 1'b1; core_rd = 5'd10; core_wdata = 32'h100;
        acc_valid = 1'b1; acc_rd = 5'd3; acc_wdata = 32'h333;
        expect_wb(5'd10, 32'h100);
        step();
        acc_valid = 1'b0;
        core_rd = 5'd11; core_wdata = 32'h101;
        expect_wb(5'd11, 32'h101);
        step();
        core_rd = 5'd12; core_wdata = 32'h102;
        expect_wb(5'd12, 32'h102);
        step();
        core_we = 1'b0;
        expect_wb(5'd3, 32'h333);
        @(negedge clk);
        check("deferred_write", {31'b0, write_reg}, 32'd1);
        step();
        @(negedge clk);
        check("deferred_drained", {31'b0, write_reg}, 32'd0);

        // Fill the FIFO behind the core, then drain in order
        for (int i = 1; i <= 5; i++) begin
            step();
            core_we = 1'b1; core_rd = 5'(19 + i); core_wdata = 32'h200 + 32'(i);
            acc_valid = 1'b1; acc_rd = 5'(i); acc_wdata = 32'hA0 + 32'(i);
            expect_wb(5'(19 + i), 32'h200 + 32'(i));
            @(negedge clk);
            if (i == 4) check("ready_before_full", {31'b0, acc_ready}, 32'd1);
            if (i == 5) check("full_not_ready", {31'b0, acc_ready}, 32'd0);
        end
        step();
        core_we = 1'b0; acc_valid = 1'b0;
        expect_wb(5'd1, 32'hA1);
        @(negedge clk);
        check("ready_during_first_pop", {31'b0, acc_ready}, 32'd0);
        for (int i = 2; i <= 4; i++) begin
            step();
            expect_wb(5'(i), 32'hA0 + 32'(i));
            @(negedge clk);
            if (i == 2) check("ready_after_first_pop", {31'b0, acc_ready}, 32'd1);
        end
        step();
        @(negedge clk);
        check("fifth_not_accepted", {31'b0, write_reg}, 32'd0);

        // Set beats clear on the same register
        step();
        issue_acc = 1'b1; issue_rd = 5'd9;
        step();
        issue_acc = 1'b0;
        acc_valid = 1'b1; acc_rd = 5'd9; acc_wdata = 32'h999;
        step();
        acc_valid = 1'b0;
        issue_acc = 1'b1; issue_rd = 5'd9;
        expect_wb(5'd9, 32'h999);
        step();
        issue_acc = 1'b0; chk_rs2 = 5'd9;
        @(negedge clk);
        check("busy9_set_wins", busy, 32'h0000_0200);
        check("stall_rs2", {31'b0, stall}, 32'd1);
        acc_valid = 1'b1; acc_rd = 5'd9; acc_wdata = 32'h9999;
        step();
        acc_valid = 1'b0;
        expect_wb(5'd9, 32'h9999);
        step();
        @(negedge clk);
        check("busy9_cleared", busy, 32'd0);
        chk_rs2 = 5'd0;

        // Accelerator result to x0 is dropped
        acc_valid = 1'b1; acc_rd = 5'd0; acc_wdata = 32'hDEAD;
        step();
        acc_valid = 1'b0;
        @(negedge clk);
        check("acc_x0_no_write", {31'b0, write_reg}, 32'd0);
        step();

        // Reset with queued results and busy bits outstanding
        issue_acc = 1'b1; issue_rd = 5'd12;
        step();
        issue_rd = 5'd13; chk_rd = 5'd13;
        step();
        issue_acc = 1'b0;
        core_we = 1'b1; core_rd = 5'd14; core_wdata = 32'h140;
        acc_valid = 1'b1; acc_rd = 5'd12; acc_wdata = 32'hC12;
        expect_wb(5'd14, 32'h140);
        step();
        core_rd = 5'd15; core_wdata = 32'h150;
        acc_rd = 5'd13; acc_wdata = 32'hC13;
        expect_wb(5'd15, 32'h150);
        @(negedge clk);
        check("busy_before_reset", busy, 32'h0000_3000);
        check("stall_waw", {31'b0, stall}, 32'd1);
        step();
        core_we = 1'b0; acc_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_write_reg", {31'b0, write_reg}, 32'd0);
        check("post_rst_busy", busy, 32'd0);
        check("post_rst_acc_ready", {31'b0, acc_ready}, 32'd1);
        check("post_rst_stall", {31'b0, stall}, 32'd0);
        step();
        @(negedge clk);
        check("post_rst_still_empty", {31'b0, write_reg}, 32'd0);

        step();
        step();
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
